glyph_hit_scheduler: RTL and testbench

Sequencer that shares one glyph hit-test datapath among `NUM_OBJ` on-screen digit objects, such as score digits. For each accepted pixel poll from the video front end, it scans every object in order. For each object it fetches the 4-wide × 9-tall glyph of that object's digit, scales the poll into glyph space, and reports whether any enabled object covers the pixel and which one. It sits between the VGA pixel-coordinate generator and the colour mux.

---
 rtl/pong_pkg.sv | 39 +++
 rtl/glyph_hit_scheduler_glyph_rom.sv | 26 ++
 rtl/glyph_hit_scheduler.sv | 160 ++++++++++++++++
 tb/tb_glyph_hit_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong display path: glyph geometry, coordinate
// widths, scheduler FSM encoding and the 4x9 digit font.
package pong_pkg;

  localparam int unsigned GLYPH_W    = 4;
  localparam int unsigned GLYPH_H    = 9;
  localparam int unsigned COORD_X_W  = 11;
  localparam int unsigned COORD_Y_W  = 10;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 10;
  localparam int unsigned CALC_W     = 14;
  localparam int unsigned GCOORD_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // One glyph column, bit r = row r (row 0 at the top)
  typedef logic [GLYPH_H-1:0] glyph_col_t;
  // Whole glyph, index = column
  typedef glyph_col_t [GLYPH_W-1:0] glyph_t;

  // Digit font, each entry written as {col3, col2, col1, col0}
  localparam glyph_t DIGIT_FONT [NUM_DIGITS] = '{
    {9'h1FF, 9'h101, 9'h101, 9'h1FF},  // 0
    {9'h1FF, 9'h000, 9'h000, 9'h000},  // 1
    {9'h11F, 9'h111, 9'h111, 9'h1F1},  // 2
    {9'h1FF, 9'h111, 9'h111, 9'h111},  // 3
    {9'h1FF, 9'h010, 9'h010, 9'h01F},  // 4
    {9'h1F1, 9'h111, 9'h111, 9'h11F},  // 5
    {9'h1F1, 9'h111, 9'h111, 9'h1FF},  // 6
    {9'h1FF, 9'h001, 9'h001, 9'h001},  // 7
    {9'h1FF, 9'h111, 9'h111, 9'h1FF},  // 8
    {9'h1FF, 9'h111, 9'h111, 9'h11F}   // 9
  };

endpackage

// File: rtl/glyph_hit_scheduler_glyph_rom.sv
// Combinational digit font lookup: (digit, column, row) -> pixel bit.
// Out-of-range digits, columns or rows read as blank.
module glyph_rom
  import pong_pkg::*;
(
  input  logic [DIGIT_W-1:0]  i_digit,
  input  logic [GCOORD_W-1:0] i_col,
  input  logic [GCOORD_W-1:0] i_row,
  output logic                o_pixel_c
);

  glyph_t w_glyph;

  // Select the glyph and pick one bit, blank when outside the font
  always_comb begin
    w_glyph   = '0;
    o_pixel_c = 1'b0;
    if (i_digit < DIGIT_W'(NUM_DIGITS)) begin
      w_glyph = DIGIT_FONT[i_digit];
    end
    if ((i_col < GCOORD_W'(GLYPH_W)) && (i_row < GCOORD_W'(GLYPH_H))) begin
      o_pixel_c = w_glyph[i_col[1:0]][i_row];
    end
  end

endmodule

// File: rtl/glyph_hit_scheduler.sv
// Time-shares one glyph hit-test datapath across NUM_OBJ digit objects.
// Optional build macro: GLYPH_HIT_EARLY_EXIT_EN (end the scan on first hit).
module glyph_hit_scheduler
  import pong_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned SCALE_W = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          poll_valid,
  output logic                          poll_ready,
  input  logic [COORD_X_W-1:0]          poll_x,
  input  logic [COORD_Y_W-1:0]          poll_y,
  input  logic [NUM_OBJ*COORD_X_W-1:0]  obj_x,
  input  logic [NUM_OBJ*COORD_Y_W-1:0]  obj_y,
  input  logic [NUM_OBJ*SCALE_W-1:0]    obj_scale,
  input  logic [NUM_OBJ*DIGIT_W-1:0]    obj_digit,
  input  logic [NUM_OBJ-1:0]            obj_en,
  output logic                          result_valid,
  output logic                          hit,
  output logic [IDX_W-1:0]              hit_index
);

  sched_state_e         r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [COORD_X_W-1:0] r_px;
  logic [COORD_Y_W-1:0] r_py;
  logic                 r_hit_flag;
  logic [IDX_W-1:0]     r_hit_idx;
  logic                 r_poll_ready;
  logic                 r_result_valid;
  logic                 r_hit;
  logic [IDX_W-1:0]     r_hit_index;

  logic [COORD_X_W-1:0] w_ox;
  logic [COORD_Y_W-1:0] w_oy;
  logic [SCALE_W-1:0]   w_scale;
  logic [DIGIT_W-1:0]   w_digit;
  logic                 w_en;
  logic [CALC_W-1:0]    w_obj_w;
  logic [CALC_W-1:0]    w_obj_h;
  logic [CALC_W-1:0]    w_dx;
  logic [CALC_W-1:0]    w_dy;
  logic                 w_inside;
  logic [GCOORD_W-1:0]  w_col;
  logic [GCOORD_W-1:0]  w_row;
  logic                 w_pix;
  logic                 w_obj_hit;
  logic                 w_first_hit;
  logic                 w_last;
  logic                 w_scan_end;
  logic                 w_final_hit;
  logic [IDX_W-1:0]     w_final_idx;

  // Mux the fields of the object currently under evaluation
  always_comb begin
    w_ox    = '0;
    w_oy    = '0;
    w_scale = '0;
    w_digit = '0;
    w_en    = 1'b0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_ox    = obj_x[k*COORD_X_W +: COORD_X_W];
        w_oy    = obj_y[k*COORD_Y_W +: COORD_Y_W];
        w_scale = obj_scale[k*SCALE_W +: SCALE_W];
        w_digit = obj_digit[k*DIGIT_W +: DIGIT_W];
        w_en    = obj_en[k];
      end
    end
  end

  // Scaled bounding box and glyph-space coordinates, all in CALC_W bits
  assign w_obj_w  = CALC_W'(GLYPH_W) << w_scale;
  assign w_obj_h  = CALC_W'(GLYPH_H) << w_scale;
  assign w_dx     = CALC_W'(r_px) - CALC_W'(w_ox);
  assign w_dy     = CALC_W'(r_py) - CALC_W'(w_oy);
  assign w_inside = (r_px >= w_ox) && (CALC_W'(r_px) < (CALC_W'(w_ox) + w_obj_w)) &&
                    (r_py >= w_oy) && (CALC_W'(r_py) < (CALC_W'(w_oy) + w_obj_h));
  assign w_col    = GCOORD_W'(w_dx >> w_scale);
  assign w_row    = GCOORD_W'(w_dy >> w_scale);

  glyph_rom u_rom (
    .i_digit   (w_digit),
    .i_col     (w_col),
    .i_row     (w_row),
    .o_pixel_c (w_pix)
  );

  assign w_obj_hit   = w_inside & w_en & w_pix;
  assign w_first_hit = w_obj_hit & ~r_hit_flag;
  assign w_last      = (r_idx == IDX_W'(NUM_OBJ - 1));
  assign w_final_hit = r_hit_flag | w_obj_hit;
  assign w_final_idx = w_first_hit ? r_idx : r_hit_idx;
`ifdef GLYPH_HIT_EARLY_EXIT_EN
  assign w_scan_end  = w_last | w_obj_hit;
`else
  assign w_scan_end  = w_last;
`endif

  // Scheduler FSM: accept poll, scan objects one per cycle, publish result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_px           <= '0;
      r_py           <= '0;
      r_hit_flag     <= 1'b0;
      r_hit_idx      <= '0;
      r_poll_ready   <= 1'b1;
      r_result_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_hit_index    <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (poll_valid && r_poll_ready) begin
            r_px         <= poll_x;
            r_py         <= poll_y;
            r_hit_flag   <= 1'b0;
            r_hit_idx    <= '0;
            r_idx        <= '0;
            r_poll_ready <= 1'b0;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_hit_flag <= w_final_hit;
          r_hit_idx  <= w_final_idx;
          if (w_scan_end) begin
            r_state        <= ST_DONE;
            r_result_valid <= 1'b1;
            r_hit          <= w_final_hit;
            r_hit_index    <= w_final_idx;
            r_idx          <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_poll_ready <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_poll_ready <= 1'b1;
        end
      endcase
    end
  end

  assign poll_ready   = r_poll_ready;
  assign result_valid = r_result_valid;
  assign hit          = r_hit;
  assign hit_index    = r_hit_index;

endmodule

// File: tb/tb_glyph_hit_scheduler.sv
// Self-checking bench for glyph_hit_scheduler against a behavioural model.
module tb_glyph_hit_scheduler;

  localparam int NUM_OBJ = 4;
  localparam int SCALE_W = 3;
  localparam int IDX_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   poll_valid;
  logic                   poll_ready;
  logic [10:0]            poll_x;
  logic [9:0]             poll_y;
  logic [NUM_OBJ*11-1:0]  obj_x;
  logic [NUM_OBJ*10-1:0]  obj_y;
  logic [NUM_OBJ*SCALE_W-1:0] obj_scale;
  logic [NUM_OBJ*4-1:0]   obj_digit;
  logic [NUM_OBJ-1:0]     obj_en;
  logic                   result_valid;
  logic                   hit;
  logic [IDX_W-1:0]       hit_index;

  int total = 0;
  int bad   = 0;

  int ox [NUM_OBJ];
  int oy [NUM_OBJ];
  int osc[NUM_OBJ];
  int odg[NUM_OBJ];
  bit oen[NUM_OBJ];

  always #5 clk = ~clk;

  glyph_hit_scheduler #(.NUM_OBJ(NUM_OBJ), .SCALE_W(SCALE_W), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .poll_valid   (poll_valid),
    .poll_ready   (poll_ready),
    .poll_x       (poll_x),
    .poll_y       (poll_y),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_scale    (obj_scale),
    .obj_digit    (obj_digit),
    .obj_en       (obj_en),
    .result_valid (result_valid),
    .hit          (hit),
    .hit_index    (hit_index)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_objs();
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_x[i*11 +: 11]           = 11'(ox[i]);
      obj_y[i*10 +: 10]           = 10'(oy[i]);
      obj_scale[i*SCALE_W +: SCALE_W] = 3'(osc[i]);
      obj_digit[i*4 +: 4]         = 4'(odg[i]);
      obj_en[i]                   = oen[i];
    end
  endtask

  // Object 0 at (100,50), scale 2, digit 0; the rest disabled
  task automatic setup_default();
    for (int i = 0; i < NUM_OBJ; i++) begin
      ox[i] = 100; oy[i] = 50; osc[i] = 2; odg[i] = 0; oen[i] = (i == 0);
    end
    apply_objs();
  endtask

  // Reference: digit 0 is a box with hollow middle columns; 10..15 are blank
  function automatic bit font_pix(input int d, input int c, input int r);
    if (d != 0) return 1'b0;
    if (c == 0 || c == 3) return 1'b1;
    return (r == 0 || r == 8);
  endfunction

  function automatic void model(input int px, input int py, output bit h, output int idx);
    h = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      int w, ht, c, r;
      w  = 4 << osc[i];
      ht = 9 << osc[i];
      if (oen[i] && px >= ox[i] && px < ox[i] + w && py >= oy[i] && py < oy[i] + ht) begin
        c = (px - ox[i]) >> osc[i];
        r = (py - oy[i]) >> osc[i];
        if (font_pix(odg[i], c, r) && !h) begin
          h = 1'b1;
          idx = i;
        end
      end
    end
  endfunction

  // Cycles from acceptance to result_valid
  function automatic int exp_latency(input bit h, input int idx);
`ifdef GLYPH_HIT_EARLY_EXIT_EN
    if (h) return 2 + idx;
`endif
    return NUM_OBJ + 1;
  endfunction

  // Issue one poll, report latency, result, and the cycle after result
  task automatic do_poll(input int px, input int py, output int lat, output bit h,
                         output int hi, output bit rdy_after, output bit rv_after);
    poll_x = 11'(px);
    poll_y = 10'(py);
    poll_valid = 1'b1;
    tick();
    poll_valid = 1'b0;
    poll_x = 11'($urandom);
    poll_y = 10'($urandom);
    lat = 1;
    while (result_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    h  = hit;
    hi = int'(hit_index);
    tick();
    rdy_after = poll_ready;
    rv_after  = result_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    poll_valid = 1'b1;
    poll_x = 11'd100;
    poll_y = 10'd50;
    setup_default();
    tick(); tick();
    total++;
    if (poll_ready !== 1'b1 || result_valid !== 1'b0 || hit !== 1'b0 || hit_index !== '0) begin
      bad++;
      $display("FAIL reset_state: ready=%b rv=%b hit=%b idx=%0d required 1 0 0 0",
               poll_ready, result_valid, hit, hit_index);
    end
    poll_valid = 1'b0;
    reset = 1'b1;
    tick();
    total++;
    if (poll_ready !== 1'b1 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready=%b rv=%b required 1 0", poll_ready, result_valid);
    end
  endtask

  task automatic test_directed();
    int px[5]  = '{100, 105, 115, 116, 100};
    int py[5]  = '{50, 70, 85, 50, 86};
    bit eh[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat, hi;
    bit h, rdy, rv;
    setup_default();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (poll_ready !== 1'b1) begin
        bad++;
        $display("FAIL dir_ready_before[%0d]: got %b required 1", k, poll_ready);
      end
      do_poll(px[k], py[k], lat, h, hi, rdy, rv);
      total++;
      if (h !== eh[k] || hi !== 0) begin
        bad++;
        $display("FAIL dir_result[%0d] (%0d,%0d): hit=%b idx=%0d required hit=%b idx=0",
                 k, px[k], py[k], h, hi, eh[k]);
      end
      total++;
      if (lat !== exp_latency(eh[k], 0)) begin
        bad++;
        $display("FAIL dir_latency[%0d]: got %0d required %0d", k, lat, exp_latency(eh[k], 0));
      end
      total++;
      if (rdy !== 1'b1 || rv !== 1'b0) begin
        bad++;
        $display("FAIL dir_after[%0d]: ready=%b rv=%b required 1 0", k, rdy, rv);
      end
    end
  endtask

  task automatic test_overlap();
    int lat, hi;
    bit h, rdy, rv;
    setup_default();
    oen[2] = 1'b1;
    apply_objs();
    do_poll(100, 50, lat, h, hi, rdy, rv);
    total++;
    if (h !== 1'b1 || hi !== 0 || lat !== exp_latency(1'b1, 0)) begin
      bad++;
      $display("FAIL overlap_lowest: hit=%b idx=%0d lat=%0d required 1 0 %0d",
               h, hi, lat, exp_latency(1'b1, 0));
    end
    oen[0] = 1'b0;
    apply_objs();
    do_poll(100, 50, lat, h, hi, rdy, rv);
    total++;
    if (h !== 1'b1 || hi !== 2 || lat !== exp_latency(1'b1, 2)) begin
      bad++;
      $display("FAIL overlap_disabled0: hit=%b idx=%0d lat=%0d required 1 2 %0d",
               h, hi, lat, exp_latency(1'b1, 2));
    end
  endtask

  task automatic test_blank();
    int lat, hi;
    bit h, rdy, rv;
    setup_default();
    odg[0] = 12;
    apply_objs();
    do_poll(100, 50, lat, h, hi, rdy, rv);
    total++;
    if (h !== 1'b0 || hi !== 0 || lat !== NUM_OBJ + 1) begin
      bad++;
      $display("FAIL blank_digit: hit=%b idx=%0d lat=%0d required 0 0 %0d", h, hi, lat, NUM_OBJ + 1);
    end
  endtask

  task automatic test_hold();
    int lat, hi;
    bit h, rdy, rv;
    setup_default();
    do_poll(115, 85, lat, h, hi, rdy, rv);
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (hit !== 1'b1 || hit_index !== '0 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL result_hold: hit=%b idx=%0d rv=%b required 1 0 0", hit, hit_index, result_valid);
    end
  endtask

  task automatic test_midscan_reset();
    int lat, hi;
    bit h, rdy, rv;
    bit seen_rv;
    setup_default();
    poll_x = 11'd100;
    poll_y = 10'd50;
    poll_valid = 1'b1;
    tick();
    poll_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (result_valid !== 1'b0 || hit !== 1'b0 || poll_ready !== 1'b1) begin
      bad++;
      $display("FAIL midscan_reset: rv=%b hit=%b ready=%b required 0 0 1", result_valid, hit, poll_ready);
    end
    seen_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (result_valid === 1'b1) seen_rv = 1'b1;
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (result_valid === 1'b1) seen_rv = 1'b1;
    end
    total++;
    if (seen_rv !== 1'b0 || poll_ready !== 1'b1) begin
      bad++;
      $display("FAIL midscan_abort: rv_seen=%b ready=%b required 0 1", seen_rv, poll_ready);
    end
    do_poll(100, 50, lat, h, hi, rdy, rv);
    total++;
    if (h !== 1'b1 || hi !== 0 || lat !== exp_latency(1'b1, 0) || rdy !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_poll: hit=%b idx=%0d lat=%0d ready=%b required 1 0 %0d 1",
               h, hi, lat, rdy, exp_latency(1'b1, 0));
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    setup_default();
    poll_x = 11'd0;
    poll_y = 10'd0;
    poll_valid = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (result_valid === 1'b1) pulses.push_back(cyc);
    end
    poll_valid = 1'b0;
    total++;
    if (pulses.size() < 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d pulses required at least 4", pulses.size());
    end else begin
      total++;
      if (pulses[0] !== NUM_OBJ + 1) begin
        bad++;
        $display("FAIL b2b_first: got cycle %0d required %0d", pulses[0], NUM_OBJ + 1);
      end
      for (int k = 1; k < pulses.size(); k++) begin
        total++;
        if (pulses[k] - pulses[k-1] !== NUM_OBJ + 2) begin
          bad++;
          $display("FAIL b2b_spacing[%0d]: got %0d required %0d", k, pulses[k] - pulses[k-1], NUM_OBJ + 2);
        end
      end
    end
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (poll_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_drain: ready=%b required 1", poll_ready);
    end
  endtask

  task automatic test_random();
    int px, py, lat, hi, eidx, k;
    bit h, rdy, rv, eh;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        ox[i]  = 90 + int'($urandom_range(0, 40));
        oy[i]  = 40 + int'($urandom_range(0, 40));
        osc[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3));
        odg[i] = ($urandom_range(0, 3) == 0) ? 10 + int'($urandom_range(0, 5)) : 0;
        oen[i] = 1'($urandom_range(0, 1));
      end
      apply_objs();
      k = int'($urandom_range(0, NUM_OBJ - 1));
      case ($urandom_range(0, 3))
        0: begin px = ox[k] + (4 << osc[k]) - int'($urandom_range(0, 1)); py = oy[k]; end
        1: begin px = ox[k]; py = oy[k] + (9 << osc[k]) - int'($urandom_range(0, 1)); end
        default: begin px = 80 + int'($urandom_range(0, 150)); py = 30 + int'($urandom_range(0, 150)); end
      endcase
      if (px > 2047) px = 2047;
      if (py > 1023) py = 1023;
      model(px, py, eh, eidx);
      do_poll(px, py, lat, h, hi, rdy, rv);
      total++;
      if (h !== eh || hi !== eidx || lat !== exp_latency(eh, eidx) || rdy !== 1'b1 || rv !== 1'b0) begin
        bad++;
        $display("FAIL rand[%0d] (%0d,%0d): hit=%b idx=%0d lat=%0d ready=%b rv=%b required hit=%b idx=%0d lat=%0d ready=1 rv=0",
                 n, px, py, h, hi, lat, rdy, rv, eh, eidx, exp_latency(eh, eidx));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    poll_valid = 1'b0;
    poll_x = '0;
    poll_y = '0;
    obj_x = '0;
    obj_y = '0;
    obj_scale = '0;
    obj_digit = '0;
    obj_en = '0;
    test_reset();
    test_directed();
    test_overlap();
    test_blank();
    test_hold();
    test_midscan_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
